uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, Sample_clock edges per bit period; the value SHALL be a power of two, 4 or greater.
REQ-003 SHALL have port Sys_clock, input, 1 bit, the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-005 SHALL have port Sample_clock, input, 1 bit, the oversample clock from the UART clock generator; it is asynchronous to Sys_clock.
REQ-006 SHALL have port Serial_in, input, 1 bit, the line; idle level is 1.
REQ-007 SHALL have port read_not_ready_in, input, 1 bit, a one-cycle host acknowledge that the word has been consumed.
REQ-008 SHALL have port RCV_datareg, output, WORD_SIZE bits, the received word.
REQ-009 SHALL have port read_not_ready_out, output, 1 bit, high while an unread word is held.
REQ-010 SHALL have port Error1, output, 1 bit, overrun error.
REQ-011 SHALL have port Error2, output, 1 bit, framing error (stop bit read as 0).

Function
REQ-012 SHALL pass Sample_clock through a 2-flop synchroniser plus a rising-edge detector, producing tick, one Sys_clock pulse per Sample_clock rise; latency is 3 Sys_clock cycles.
REQ-013 SHALL synchronise Serial_in through 2 flops, producing rx.
REQ-014 SHALL advance all FSM and counter activity only on tick; between ticks all state SHALL hold.
REQ-015 FSM SHALL have states IDLE, START, DATA, STOP, plus PAR when UART_RX_PARITY_EN is defined.
REQ-016 IDLE SHALL move to START on a tick with rx=0, clearing sample_cnt.
REQ-017 START SHALL count ticks; at sample_cnt=OVERSAMPLE/2-1 it SHALL go to DATA if rx=0, otherwise to IDLE (glitch rejection).
REQ-018 On entry to DATA, sample_cnt and bit_cnt SHALL clear.
REQ-019 DATA SHALL sample rx when sample_cnt=OVERSAMPLE-1, shifting it in LSB-first (right shift, new bit into MSB); bit_cnt SHALL then increment and sample_cnt SHALL clear.
REQ-020 DATA SHALL exit after WORD_SIZE samples.
REQ-021 STOP SHALL sample rx at sample_cnt=OVERSAMPLE-1.
REQ-022 On the STOP sample, RCV_datareg SHALL load the shift register and read_not_ready_out SHALL set.
REQ-023 On the STOP sample, Error2 SHALL set if rx=0.
REQ-024 On the STOP sample, Error1 SHALL set if read_not_ready_out was already 1; the new word overwrites the old one.
REQ-025 After the STOP sample the FSM SHALL return to IDLE; the next start bit SHALL be accepted on the following tick.
REQ-026 read_not_ready_in=1 SHALL clear read_not_ready_out, Error1 and Error2 on the next Sys_clock edge.
REQ-027 If read_not_ready_in and the STOP load occur in the same cycle, the load SHALL win: ready=1, Error1=0.
REQ-028 Error flags SHALL be sticky until acknowledged or reset.
REQ-029 Counters SHALL be clog2-sized and SHALL never wrap within a state.

Reset
REQ-030 reset=1 SHALL asynchronously force: FSM to IDLE, all counters to 0, shift register and RCV_datareg to 0, read_not_ready_out, Error1 and Error2 to 0, synchroniser flops to 1 on the Serial_in path and 0 on the Sample_clock path.
REQ-031 A frame interrupted by reset SHALL be discarded with no output change after deassertion.

Configuration
REQ-032 When UART_RX_PARITY_EN is defined, the PAR state SHALL follow DATA and sample an even-parity bit at sample_cnt=OVERSAMPLE-1.
REQ-033 With UART_RX_PARITY_EN defined, output Error3 (parity error, sticky, cleared like Error1) SHALL be added, reset value 0.
REQ-034 Without UART_RX_PARITY_EN, the PAR state and the Error3 port SHALL not exist, and DATA SHALL go directly to STOP.

Structure
REQ-035 Shared package uart_pkg SHALL hold the FSM state enum and the OVERSAMPLE_DEFAULT and WORD_SIZE_DEFAULT constants.
REQ-036 The synchroniser and edge detector SHALL be sub-module uart_rx_sync, instantiated twice: edge output used for Sample_clock, level output used for Serial_in.

Verification
REQ-037 Frame 0x5A, 8N1, correct stop bit -> RCV_datareg=0x5A, read_not_ready_out=1 after the stop-bit centre, Error1=0 and Error2=0.
REQ-038 Line low for 2 ticks then high -> FSM back to IDLE, no load, outputs unchanged.
REQ-039 Frame 0xA5 with stop bit=0 -> RCV_datareg=0xA5, Error2=1; after a read_not_ready_in pulse, Error2=0 and read_not_ready_out=0.
REQ-040 Two frames 0x11 then 0x22 with no acknowledge -> RCV_datareg=0x22, Error1=1.
REQ-041 reset asserted mid-DATA of 0xFF, then frame 0x3C -> only 0x3C delivered, no error flags.
REQ-042 With UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> Error3=1; with parity bit 1 -> Error3=0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - OVERSAMPLE_DEFAULT / WORD_SIZE_DEFAULT : default parameter values
//   - *_CODE localparams                     : fixed state encodings
//   - uart_rx_state_e                        : receiver FSM state type
// Optional feature macro: UART_RX_PARITY_EN adds the PAR state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 8;
    localparam int WORD_SIZE_DEFAULT  = 8;

    // Encodings are pinned so they stay stable for anything that decodes
    // the state register by value.
    localparam logic [2:0] IDLE_CODE  = 3'd0;
    localparam logic [2:0] START_CODE = 3'd1;
    localparam logic [2:0] DATA_CODE  = 3'd2;
    localparam logic [2:0] STOP_CODE  = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PAR_CODE   = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE  = IDLE_CODE,
        START = START_CODE,
        DATA  = DATA_CODE,
        STOP  = STOP_CODE
`ifdef UART_RX_PARITY_EN
        ,
        PAR   = PAR_CODE
`endif
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for a signal asynchronous to clk, with an optional
// registered rising-edge detector.
//   EDGE_MODE = 0 : dout is the synchronised level (2 cycles latency)
//   EDGE_MODE = 1 : dout is a one-cycle pulse per rising edge of din
//                   (3 cycles latency from the din edge)
//   RESET_VAL     : value the synchroniser flops take during reset
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   din   : asynchronous input
//   dout  : synchronised level or edge pulse, depending on EDGE_MODE
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter bit RESET_VAL = 1'b0,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    generate
        if (EDGE_MODE) begin : g_edge
            logic prev_reg;
            logic rise_reg;

            // The pulse is registered so downstream logic sees a clean flop
            // output rather than a combinational compare of two stages.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prev_reg <= RESET_VAL;
                    rise_reg <= 1'b0;
                end else begin
                    prev_reg <= sync_reg;
                    rise_reg <= sync_reg & ~prev_reg;
                end
            end

            assign dout = rise_reg;
        end else begin : g_level
            assign dout = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Oversampling UART receiver (LSB first, 1 start bit, WORD_SIZE data bits,
// optional even parity, 1 stop bit). All FSM/counter activity advances only
// on 'tick', derived from rising edges of the asynchronous Sample_clock.
// Optional feature macro: UART_RX_PARITY_EN (adds PAR state and Error3).
// Parameters:
//   WORD_SIZE  : data bits per frame (2 or more)
//   OVERSAMPLE : Sample_clock edges per bit, power of two, 4 or more
// Ports:
//   Sys_clock          : system clock, rising edge
//   reset              : asynchronous active-high reset
//   Sample_clock       : oversample clock (asynchronous to Sys_clock)
//   Serial_in          : serial line, idle high
//   read_not_ready_in  : one-cycle host acknowledge of the held word
//   RCV_datareg        : received word
//   read_not_ready_out : an unread word is held
//   Error1             : overrun (word overwritten before acknowledge)
//   Error2             : framing error (stop bit sampled low)
//   Error3             : parity error (only with UART_RX_PARITY_EN)
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 Sys_clock,
    input  logic                 reset,
    input  logic                 Sample_clock,
    input  logic                 Serial_in,
    input  logic                 read_not_ready_in,
    output logic [WORD_SIZE-1:0] RCV_datareg,
    output logic                 read_not_ready_out,
    output logic                 Error1,
    output logic                 Error2
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 Error3
`endif
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    localparam logic [SW-1:0] CNT_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);

    logic tick;
    logic rx;

    // Sample_clock: edge pulse, idle-low synchroniser.
    uart_rx_sync #(
        .RESET_VAL (1'b0),
        .EDGE_MODE (1'b1)
    ) u_sample_sync (
        .clk   (Sys_clock),
        .reset (reset),
        .din   (Sample_clock),
        .dout  (tick)
    );

    // Serial_in: level, idle-high synchroniser so reset never looks like a start bit.
    uart_rx_sync #(
        .RESET_VAL (1'b1),
        .EDGE_MODE (1'b0)
    ) u_serial_sync (
        .clk   (Sys_clock),
        .reset (reset),
        .din   (Serial_in),
        .dout  (rx)
    );

    uart_rx_state_e      state_reg,      state_next;
    logic [SW-1:0]       sample_cnt_reg, sample_cnt_next;
    logic [BW-1:0]       bit_cnt_reg,    bit_cnt_next;
    logic [WORD_SIZE-1:0] shift_reg,     shift_next;
    logic [WORD_SIZE-1:0] data_reg,      data_next;
    logic                ready_reg,      ready_next;
    logic                err1_reg,       err1_next;
    logic                err2_reg,       err2_next;
`ifdef UART_RX_PARITY_EN
    logic                err3_reg,       err3_next;
`endif

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        data_next       = data_reg;
        // The host acknowledge acts on every Sys_clock edge, not only on ticks.
        ready_next      = ready_reg & ~read_not_ready_in;
        err1_next       = err1_reg  & ~read_not_ready_in;
        err2_next       = err2_reg  & ~read_not_ready_in;
`ifdef UART_RX_PARITY_EN
        err3_next       = err3_reg  & ~read_not_ready_in;
`endif

        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx) begin
                        state_next      = START;
                        sample_cnt_next = '0;
                    end
                end

                START: begin
                    // Re-check the line mid start bit; a short low pulse is
                    // treated as noise and dropped.
                    if (sample_cnt_reg == CNT_HALF) begin
                        sample_cnt_next = '0;
                        bit_cnt_next    = '0;
                        state_next      = rx ? IDLE : DATA;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end

                DATA: begin
                    if (sample_cnt_reg == CNT_LAST) begin
                        sample_cnt_next = '0;
                        // LSB first: new bit enters at the MSB, word shifts right.
                        shift_next      = WORD_SIZE'({rx, shift_reg} >> 1);
                        if (bit_cnt_reg == BIT_LAST) begin
                            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                            state_next   = PAR;
`else
                            state_next   = STOP;
`endif
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BW'(1);
                        end
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PAR: begin
                    if (sample_cnt_reg == CNT_LAST) begin
                        sample_cnt_next = '0;
                        // Even parity: data plus parity bit must hold an even
                        // number of ones.
                        if (^{shift_reg, rx}) begin
                            err3_next = 1'b1;
                        end
                        state_next = STOP;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
`endif

                STOP: begin
                    if (sample_cnt_reg == CNT_LAST) begin
                        sample_cnt_next = '0;
                        data_next       = shift_reg;
                        // The load beats a same-cycle acknowledge; overrun only
                        // counts if the old word was not consumed this cycle.
                        ready_next      = 1'b1;
                        err1_next       = err1_next | (ready_reg & ~read_not_ready_in);
                        err2_next       = err2_next | ~rx;
                        state_next      = IDLE;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end

                default: begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    bit_cnt_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            ready_reg      <= 1'b0;
            err1_reg       <= 1'b0;
            err2_reg       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            err3_reg       <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            ready_reg      <= ready_next;
            err1_reg       <= err1_next;
            err2_reg       <= err2_next;
`ifdef UART_RX_PARITY_EN
            err3_reg       <= err3_next;
`endif
        end
    end

    assign RCV_datareg        = data_reg;
    assign read_not_ready_out = ready_reg;
    assign Error1             = err1_reg;
    assign Error2             = err2_reg;
`ifdef UART_RX_PARITY_EN
    assign Error3             = err3_reg;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed self-checking bench for uart_rx_core (WORD_SIZE=8, OVERSAMPLE=8).
// Serial_in changes on falling edges of Sample_clock; outputs are sampled on
// Sys_clock falling edges (Sample_clock edges coincide with those).
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int OS = 8;
    localparam int WS = 8;

    logic          Sys_clock = 1'b0;
    logic          reset = 1'b0;
    logic          Sample_clock = 1'b0;
    logic          Serial_in = 1'b1;
    logic          read_not_ready_in = 1'b0;
    logic [WS-1:0] RCV_datareg;
    logic          read_not_ready_out;
    logic          Error1;
    logic          Error2;
`ifdef UART_RX_PARITY_EN
    logic          Error3;
    logic          par_flip = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5  Sys_clock    = ~Sys_clock;
    always #40 Sample_clock = ~Sample_clock;

    uart_rx_core #(
        .WORD_SIZE  (WS),
        .OVERSAMPLE (OS)
    ) dut (
        .Sys_clock          (Sys_clock),
        .reset              (reset),
        .Sample_clock       (Sample_clock),
        .Serial_in          (Serial_in),
        .read_not_ready_in  (read_not_ready_in),
        .RCV_datareg        (RCV_datareg),
        .read_not_ready_out (read_not_ready_out),
        .Error1             (Error1),
        .Error2             (Error2)
`ifdef UART_RX_PARITY_EN
        ,
        .Error3             (Error3)
`endif
    );

    task automatic send_bit(input logic b);
        Serial_in = b;
        repeat (OS) @(negedge Sample_clock);
    endtask

    // Start bit plus data bits (and parity bit when enabled), LSB first.
    task automatic send_head(input logic [WS-1:0] d);
        @(negedge Sample_clock);
        send_bit(1'b0);
        for (int i = 0; i < WS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [WS-1:0] d, input logic stop_b);
        send_head(d);
        send_bit(stop_b);
        Serial_in = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge Sys_clock);
        read_not_ready_in = 1'b1;
        @(negedge Sys_clock);
        read_not_ready_in = 1'b0;
        @(negedge Sys_clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge Sys_clock);
        total++; if (RCV_datareg !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", RCV_datareg); end
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", read_not_ready_out); end
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL reset_err1: got %b want 0", Error1); end
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL reset_err2: got %b want 0", Error2); end
`ifdef UART_RX_PARITY_EN
        total++; if (Error3 !== 1'b0) begin bad++; $display("FAIL reset_err3: got %b want 0", Error3); end
`endif
        reset = 1'b0;
        repeat (2 * OS) @(negedge Sample_clock);
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_good_frame();
        send_head(8'h5A);
        Serial_in = 1'b1;
        // Two ticks into the stop bit: the stop sample has not happened yet.
        repeat (2) @(negedge Sample_clock);
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL good_early_ready: got %b want 0", read_not_ready_out); end
        repeat (OS - 2) @(negedge Sample_clock);
        total++; if (RCV_datareg !== 8'h5A) begin bad++; $display("FAIL good_data: got %h want 5a", RCV_datareg); end
        total++; if (read_not_ready_out !== 1'b1) begin bad++; $display("FAIL good_ready: got %b want 1", read_not_ready_out); end
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL good_err1: got %b want 0", Error1); end
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL good_err2: got %b want 0", Error2); end
        ack_pulse();
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL good_ack_ready: got %b want 0", read_not_ready_out); end
        $display("test_good_frame: frame 5a data=%h", RCV_datareg);
    endtask

    task automatic test_glitch();
        @(negedge Sample_clock);
        Serial_in = 1'b0;
        repeat (2) @(negedge Sample_clock);
        Serial_in = 1'b1;
        repeat (3 * OS) @(negedge Sample_clock);
        total++; if (RCV_datareg !== 8'h5A) begin bad++; $display("FAIL glitch_data: got %h want 5a", RCV_datareg); end
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL glitch_ready: got %b want 0", read_not_ready_out); end
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL glitch_err2: got %b want 0", Error2); end
        $display("test_glitch: 2-tick low pulse, data=%h", RCV_datareg);
    endtask

    task automatic test_framing();
        send_frame(8'hA5, 1'b0);
        repeat (2 * OS) @(negedge Sample_clock);
        total++; if (RCV_datareg !== 8'hA5) begin bad++; $display("FAIL frame_data: got %h want a5", RCV_datareg); end
        total++; if (Error2 !== 1'b1) begin bad++; $display("FAIL frame_err2: got %b want 1", Error2); end
        total++; if (read_not_ready_out !== 1'b1) begin bad++; $display("FAIL frame_ready: got %b want 1", read_not_ready_out); end
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL frame_err1: got %b want 0", Error1); end
        ack_pulse();
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL frame_ack_err2: got %b want 0", Error2); end
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL frame_ack_ready: got %b want 0", read_not_ready_out); end
        $display("test_framing: frame a5 with low stop bit");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1);
        total++; if (RCV_datareg !== 8'h11) begin bad++; $display("FAIL b2b_first_data: got %h want 11", RCV_datareg); end
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL b2b_first_err1: got %b want 0", Error1); end
        send_frame(8'h22, 1'b1);
        total++; if (RCV_datareg !== 8'h22) begin bad++; $display("FAIL b2b_data: got %h want 22", RCV_datareg); end
        total++; if (Error1 !== 1'b1) begin bad++; $display("FAIL b2b_err1: got %b want 1", Error1); end
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL b2b_err2: got %b want 0", Error2); end
        ack_pulse();
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL b2b_ack_err1: got %b want 0", Error1); end
        $display("test_back_to_back: frames 11 then 22 without acknowledge");
    endtask

    task automatic test_reset_mid_frame();
        @(negedge Sample_clock);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        repeat (3) @(negedge Sys_clock);
        reset = 1'b0;
        Serial_in = 1'b1;
        repeat (12 * OS) @(negedge Sample_clock);
        total++; if (RCV_datareg !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h want 00", RCV_datareg); end
        total++; if (read_not_ready_out !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got %b want 0", read_not_ready_out); end
        send_frame(8'h3C, 1'b1);
        total++; if (RCV_datareg !== 8'h3C) begin bad++; $display("FAIL rst_next_data: got %h want 3c", RCV_datareg); end
        total++; if (read_not_ready_out !== 1'b1) begin bad++; $display("FAIL rst_next_ready: got %b want 1", read_not_ready_out); end
        total++; if (Error1 !== 1'b0) begin bad++; $display("FAIL rst_next_err1: got %b want 0", Error1); end
        total++; if (Error2 !== 1'b0) begin bad++; $display("FAIL rst_next_err2: got %b want 0", Error2); end
        ack_pulse();
        $display("test_reset_mid_frame: reset during ff, then 3c delivered");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        // 0x07 has three ones: even parity bit is 1, so flipping sends 0.
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        total++; if (Error3 !== 1'b1) begin bad++; $display("FAIL par_bad_err3: got %b want 1", Error3); end
        total++; if (RCV_datareg !== 8'h07) begin bad++; $display("FAIL par_bad_data: got %h want 07", RCV_datareg); end
        ack_pulse();
        total++; if (Error3 !== 1'b0) begin bad++; $display("FAIL par_ack_err3: got %b want 0", Error3); end
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        total++; if (Error3 !== 1'b0) begin bad++; $display("FAIL par_good_err3: got %b want 0", Error3); end
        ack_pulse();
        $display("test_parity: frame 07 with parity 0 and 1");
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
